// File: rtl/pspin_egress_cmd_arbiter.sv
// Round-robin arbiter merging per-cluster NIC commands onto one egress DMA port,
// with in-order completion routing. Optional macro PSPIN_EGRESS_ARB_STATS_EN adds per-requester issue counters.
module pspin_egress_cmd_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int CMD_ID_WIDTH    = 6,
  parameter int HOST_ADDR_WIDTH = 64,
  parameter int LEN_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   s_cmd_valid,
  output logic [NUM_REQ-1:0]                   s_cmd_ready,
  input  logic [NUM_REQ*CMD_ID_WIDTH-1:0]      s_cmd_id,
  input  logic [NUM_REQ*HOST_ADDR_WIDTH-1:0]   s_cmd_src_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]         s_cmd_length,
  output logic                                 m_cmd_valid,
  input  logic                                 m_cmd_ready,
  output logic [CMD_ID_WIDTH-1:0]              m_cmd_id,
  output logic [HOST_ADDR_WIDTH-1:0]           m_cmd_src_addr,
  output logic [LEN_WIDTH-1:0]                 m_cmd_length,
  input  logic                                 s_status_valid,
  input  logic [CMD_ID_WIDTH-1:0]              s_status_tag,
  input  logic [3:0]                           s_status_error,
  output logic [NUM_REQ-1:0]                   m_resp_valid,
  output logic [CMD_ID_WIDTH-1:0]              m_resp_id,
  output logic [3:0]                           m_resp_error,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 spurious_status
`ifdef PSPIN_EGRESS_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]                stat_issued
`endif
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTRW = $clog2(MAX_OUTSTANDING);
  localparam int CNTW = PTRW + 1;

  typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

  state_t                       r_state, w_state_nxt;
  logic [IDXW-1:0]              r_last;
  logic [IDXW-1:0]              r_cmd_src;
  logic [CMD_ID_WIDTH-1:0]      r_cmd_id;
  logic [HOST_ADDR_WIDTH-1:0]   r_cmd_addr;
  logic [LEN_WIDTH-1:0]         r_cmd_len;
  logic [CNTW-1:0]              r_cnt;
  logic [IDXW-1:0]              r_fifo [MAX_OUTSTANDING];
  logic [PTRW-1:0]              r_wptr, r_rptr;
  logic [NUM_REQ-1:0]           r_resp_valid;
  logic [CMD_ID_WIDTH-1:0]      r_resp_id;
  logic [3:0]                   r_resp_err;
  logic                         r_spurious;

  logic                         w_found;
  logic [IDXW-1:0]              w_win;
  logic [CMD_ID_WIDTH-1:0]      w_sel_id;
  logic [HOST_ADDR_WIDTH-1:0]   w_sel_addr;
  logic [LEN_WIDTH-1:0]         w_sel_len;
  logic [CNTW-1:0]              w_inflight;
  logic                         w_slot_free;
  logic                         w_room;
  logic                         w_grant;
  logic                         w_issue;
  logic                         w_pop;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(r_last) + k) % NUM_REQ;
      if (!w_found && s_cmd_valid[j]) begin
        w_found = 1'b1;
        w_win   = IDXW'(j);
      end
    end
  end

  always_comb begin
    w_sel_id   = '0;
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDXW'(i)) begin
        w_sel_id   = s_cmd_id[i*CMD_ID_WIDTH +: CMD_ID_WIDTH];
        w_sel_addr = s_cmd_src_addr[i*HOST_ADDR_WIDTH +: HOST_ADDR_WIDTH];
        w_sel_len  = s_cmd_length[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // The held command counts against the budget even before it handshakes.
  assign w_inflight  = r_cnt + CNTW'(r_state == S_HOLD);
  assign w_room      = (w_inflight < CNTW'(MAX_OUTSTANDING));
  assign w_slot_free = (r_state == S_EMPTY) || m_cmd_ready;
  assign w_grant     = !rst && w_slot_free && w_found && w_room;
  assign w_issue     = (r_state == S_HOLD) && m_cmd_ready;
  assign w_pop       = s_status_valid && (r_cnt != '0);

  assign s_cmd_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_grant) w_state_nxt = S_HOLD;
      S_HOLD:  if (m_cmd_ready && !w_grant) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= IDXW'(NUM_REQ - 1);
      r_cmd_src  <= '0;
      r_cmd_id   <= '0;
      r_cmd_addr <= '0;
      r_cmd_len  <= '0;
    end else if (w_grant) begin
      r_last     <= w_win;
      r_cmd_src  <= w_win;
      r_cmd_id   <= w_sel_id;
      r_cmd_addr <= w_sel_addr;
      r_cmd_len  <= w_sel_len;
    end
  end

  // Completions return in issue order, so a plain FIFO of source indices suffices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
    end else begin
      if (w_issue) begin
        r_fifo[r_wptr] <= r_cmd_src;
        r_wptr         <= r_wptr + PTRW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTRW'(1);
      case ({w_issue, w_pop})
        2'b10:   r_cnt <= r_cnt + CNTW'(1);
        2'b01:   r_cnt <= r_cnt - CNTW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= '0;
      r_resp_id    <= '0;
      r_resp_err   <= '0;
      r_spurious   <= 1'b0;
    end else begin
      r_resp_valid <= w_pop ? (NUM_REQ'(1) << r_fifo[r_rptr]) : '0;
      if (w_pop) begin
        r_resp_id  <= s_status_tag;
        r_resp_err <= s_status_error;
      end
      if (s_status_valid && (r_cnt == '0)) r_spurious <= 1'b1;
    end
  end

  assign m_cmd_valid     = (r_state == S_HOLD);
  assign m_cmd_id        = r_cmd_id;
  assign m_cmd_src_addr  = r_cmd_addr;
  assign m_cmd_length    = r_cmd_len;
  assign m_resp_valid    = r_resp_valid;
  assign m_resp_id       = r_resp_id;
  assign m_resp_error    = r_resp_err;
  assign outstanding     = r_cnt;
  assign spurious_status = r_spurious;

`ifdef PSPIN_EGRESS_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [31:0] r_issued;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    r_issued <= '0;
      else if (w_issue && r_cmd_src == IDXW'(g)) r_issued <= r_issued + 32'd1;
    end
    assign stat_issued[g*32 +: 32] = r_issued;
  end
`endif

endmodule

// File: tb/tb_pspin_egress_cmd_arbiter.sv
// Directed testbench for pspin_egress_cmd_arbiter (default parameters, 2 requesters, 4 in flight).
module tb_pspin_egress_cmd_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   s_cmd_valid, s_cmd_ready;
  logic [11:0]  s_cmd_id;
  logic [127:0] s_cmd_src_addr;
  logic [63:0]  s_cmd_length;
  logic         m_cmd_valid, m_cmd_ready;
  logic [5:0]   m_cmd_id;
  logic [63:0]  m_cmd_src_addr;
  logic [31:0]  m_cmd_length;
  logic         s_status_valid;
  logic [5:0]   s_status_tag;
  logic [3:0]   s_status_error;
  logic [1:0]   m_resp_valid;
  logic [5:0]   m_resp_id;
  logic [3:0]   m_resp_error;
  logic [2:0]   outstanding;
  logic         spurious_status;

  int n_tests = 0;
  int n_fail  = 0;

  pspin_egress_cmd_arbiter dut (
    .clk(clk), .rst(rst),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_id(s_cmd_id), .s_cmd_src_addr(s_cmd_src_addr), .s_cmd_length(s_cmd_length),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_id(m_cmd_id), .m_cmd_src_addr(m_cmd_src_addr), .m_cmd_length(m_cmd_length),
    .s_status_valid(s_status_valid), .s_status_tag(s_status_tag), .s_status_error(s_status_error),
    .m_resp_valid(m_resp_valid), .m_resp_id(m_resp_id), .m_resp_error(m_resp_error),
    .outstanding(outstanding), .spurious_status(spurious_status)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    s_cmd_valid    = '0;
    s_cmd_id       = '0;
    s_cmd_src_addr = '0;
    s_cmd_length   = '0;
    m_cmd_ready    = 1'b0;
    s_status_valid = 1'b0;
    s_status_tag   = '0;
    s_status_error = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if ({m_cmd_valid, s_cmd_ready, m_resp_valid, m_resp_id, m_resp_error, outstanding, spurious_status} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: cmd_v=%b rdy=%b resp_v=%b id=%0d err=%0d out=%0d spur=%b, required all 0",
               m_cmd_valid, s_cmd_ready, m_resp_valid, m_resp_id, m_resp_error, outstanding, spurious_status);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [5:0] exp_id [4];
    exp_id = '{6'd10, 6'd20, 6'd10, 6'd20};
    do_reset();
    s_cmd_id       = {6'd20, 6'd10};
    s_cmd_src_addr = {64'hB000, 64'hA000};
    s_cmd_length   = {32'd200, 32'd100};
    s_cmd_valid    = 2'b11;
    m_cmd_ready    = 1'b1;
    #1;
    n_tests++;
    if (s_cmd_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_first_grant: s_cmd_ready=%b, required 01", s_cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (m_cmd_valid !== 1'b1 || m_cmd_id !== exp_id[i]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: valid=%b id=%0d, required 1/%0d", i, m_cmd_valid, m_cmd_id, exp_id[i]);
      end
    end
    n_tests++;
    if (m_cmd_src_addr !== 64'hB000 || m_cmd_length !== 32'd200) begin
      n_fail++;
      $display("FAIL rr_payload: addr=%h len=%0d, required b000/200", m_cmd_src_addr, m_cmd_length);
    end
    s_cmd_valid = '0;
  endtask

  task automatic test_outstanding_limit;
    int grants;
    grants = 0;
    do_reset();
    s_cmd_id    = {6'd33, 6'd0};
    s_cmd_valid = 2'b10;
    m_cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (s_cmd_ready[1]) grants++;
      tick();
    end
    n_tests++;
    if (grants != 4) begin
      n_fail++;
      $display("FAIL limit_grants: grants=%0d, required 4", grants);
    end
    n_tests++;
    if (outstanding !== 3'd4 || m_cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_full: outstanding=%0d cmd_v=%b, required 4/0", outstanding, m_cmd_valid);
    end
    s_status_valid = 1'b1;
    s_status_tag   = 6'd33;
    #1;
    n_tests++;
    if (s_cmd_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL limit_blocked: s_cmd_ready=%b, required 00", s_cmd_ready);
    end
    tick();
    s_status_valid = 1'b0;
    #1;
    n_tests++;
    if (s_cmd_ready !== 2'b10 || outstanding !== 3'd3 || m_resp_valid !== 2'b10) begin
      n_fail++;
      $display("FAIL limit_regrant: rdy=%b out=%0d resp_v=%b, required 10/3/10", s_cmd_ready, outstanding, m_resp_valid);
    end
    tick();
    s_cmd_valid = '0;
    n_tests++;
    if (m_cmd_valid !== 1'b1 || m_cmd_id !== 6'd33) begin
      n_fail++;
      $display("FAIL limit_fifth_issue: valid=%b id=%0d, required 1/33", m_cmd_valid, m_cmd_id);
    end
  endtask

  task automatic test_status_routing;
    do_reset();
    m_cmd_ready = 1'b1;
    s_cmd_id    = {6'd9, 6'd5};
    s_cmd_valid = 2'b01;
    tick();
    s_cmd_valid = 2'b10;
    tick();
    s_cmd_valid = 2'b00;
    tick();
    tick();
    n_tests++;
    if (outstanding !== 3'd2) begin
      n_fail++;
      $display("FAIL route_inflight: outstanding=%0d, required 2", outstanding);
    end
    s_status_valid = 1'b1;
    s_status_tag   = 6'd5;
    s_status_error = 4'd0;
    tick();
    s_status_tag   = 6'd9;
    s_status_error = 4'd3;
    n_tests++;
    if (m_resp_valid !== 2'b01 || m_resp_id !== 6'd5 || m_resp_error !== 4'd0) begin
      n_fail++;
      $display("FAIL route_first: resp_v=%b id=%0d err=%0d, required 01/5/0", m_resp_valid, m_resp_id, m_resp_error);
    end
    tick();
    s_status_valid = 1'b0;
    n_tests++;
    if (m_resp_valid !== 2'b10 || m_resp_id !== 6'd9 || m_resp_error !== 4'd3 || outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL route_second: resp_v=%b id=%0d err=%0d out=%0d, required 10/9/3/0",
               m_resp_valid, m_resp_id, m_resp_error, outstanding);
    end
    tick();
    n_tests++;
    if (m_resp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL route_pulse_width: resp_v=%b, required 00", m_resp_valid);
    end
  endtask

  task automatic test_hold_stable;
    do_reset();
    m_cmd_ready    = 1'b0;
    s_cmd_id       = {6'd11, 6'd7};
    s_cmd_src_addr = {64'hCAFE, 64'h1234_5678};
    s_cmd_length   = {32'd8, 32'd64};
    s_cmd_valid    = 2'b11;
    tick();
    s_cmd_id       = {6'd11, 6'd33};
    s_cmd_src_addr = {64'hCAFE, 64'hDEAD};
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (m_cmd_valid !== 1'b1 || m_cmd_id !== 6'd7 || m_cmd_src_addr !== 64'h1234_5678 ||
          m_cmd_length !== 32'd64 || s_cmd_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: v=%b id=%0d addr=%h len=%0d rdy=%b, required 1/7/12345678/64/00",
                 i, m_cmd_valid, m_cmd_id, m_cmd_src_addr, m_cmd_length, s_cmd_ready);
      end
      tick();
    end
    m_cmd_ready = 1'b1;
    #1;
    n_tests++;
    if (s_cmd_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL hold_release_grant: s_cmd_ready=%b, required 10", s_cmd_ready);
    end
    tick();
    s_cmd_valid = '0;
    n_tests++;
    if (m_cmd_id !== 6'd11 || m_cmd_src_addr !== 64'hCAFE) begin
      n_fail++;
      $display("FAIL hold_next_cmd: id=%0d addr=%h, required 11/cafe", m_cmd_id, m_cmd_src_addr);
    end
  endtask

  task automatic test_spurious;
    do_reset();
    s_status_valid = 1'b1;
    s_status_tag   = 6'd3;
    tick();
    s_status_valid = 1'b0;
    n_tests++;
    if (m_resp_valid !== 2'b00 || spurious_status !== 1'b1 || outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL spurious: resp_v=%b spur=%b out=%0d, required 00/1/0", m_resp_valid, spurious_status, outstanding);
    end
    tick();
    tick();
    n_tests++;
    if (spurious_status !== 1'b1 || outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL spurious_sticky: spur=%b out=%0d, required 1/0", spurious_status, outstanding);
    end
  endtask

  task automatic test_reset_inflight;
    do_reset();
    s_status_valid = 1'b1;
    tick();
    s_status_valid = 1'b0;
    s_cmd_id       = {6'd0, 6'd21};
    s_cmd_valid    = 2'b01;
    m_cmd_ready    = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (outstanding !== 3'd4) begin
      n_fail++;
      $display("FAIL rstfl_fill: outstanding=%0d, required 4", outstanding);
    end
    s_status_valid = 1'b1;
    s_status_tag   = 6'd2;
    s_status_error = 4'd5;
    tick();
    s_status_valid = 1'b0;
    #1;
    n_tests++;
    if (outstanding !== 3'd3 || m_resp_valid !== 2'b01 || m_resp_error !== 4'd5 ||
        s_cmd_ready !== 2'b01 || spurious_status !== 1'b1) begin
      n_fail++;
      $display("FAIL rstfl_pre: out=%0d resp_v=%b err=%0d rdy=%b spur=%b, required 3/01/5/01/1",
               outstanding, m_resp_valid, m_resp_error, s_cmd_ready, spurious_status);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({m_cmd_valid, s_cmd_ready, m_resp_valid, m_resp_id, m_resp_error, outstanding, spurious_status} !== '0) begin
      n_fail++;
      $display("FAIL rstfl_async: cmd_v=%b rdy=%b resp_v=%b id=%0d err=%0d out=%0d spur=%b, required all 0",
               m_cmd_valid, s_cmd_ready, m_resp_valid, m_resp_id, m_resp_error, outstanding, spurious_status);
    end
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (s_cmd_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rstfl_regrant: s_cmd_ready=%b, required 01", s_cmd_ready);
    end
    tick();
    s_cmd_valid = '0;
    n_tests++;
    if (m_cmd_valid !== 1'b1 || m_cmd_id !== 6'd21 || outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL rstfl_issue: v=%b id=%0d out=%0d, required 1/21/0", m_cmd_valid, m_cmd_id, outstanding);
    end
    tick();
    n_tests++;
    if (outstanding !== 3'd1 || m_cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstfl_count: out=%0d v=%b, required 1/0", outstanding, m_cmd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_outstanding_limit();
    test_status_routing();
    test_hold_stable();
    test_spurious();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pspin_egress_cmd_arbiter.md
PSPIN_EGRESS_CMD_ARBITER -- requirements
Module: pspin_egress_cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of NIC-command requesters (clusters).
REQ-002 SHALL have parameter CMD_ID_WIDTH, default 6: NIC command ID width.
REQ-003 SHALL have parameter HOST_ADDR_WIDTH, default 64: source address width.
REQ-004 SHALL have parameter LEN_WIDTH, default 32: length field width.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4: power of two, at least 2; maximum commands in flight to the egress DMA.
REQ-006 SHALL have port clk, input, 1: the single clock. All logic is synchronous to it.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port s_cmd_valid, input, NUM_REQ: per-requester command valid.
REQ-009 SHALL have port s_cmd_ready, output, NUM_REQ: per-requester command ready.
REQ-010 SHALL have port s_cmd_id, input, NUM_REQ*CMD_ID_WIDTH: packed per-requester command ID.
REQ-011 SHALL have port s_cmd_src_addr, input, NUM_REQ*HOST_ADDR_WIDTH: packed per-requester source address.
REQ-012 SHALL have port s_cmd_length, input, NUM_REQ*LEN_WIDTH: packed per-requester byte length.
REQ-013 SHALL have ports m_cmd_valid (output, 1), m_cmd_ready (input, 1), m_cmd_id (output, CMD_ID_WIDTH), m_cmd_src_addr (output, HOST_ADDR_WIDTH) and m_cmd_length (output, LEN_WIDTH): the command to the egress DMA descriptor port.
REQ-014 SHALL have ports s_status_valid (input, 1), s_status_tag (input, CMD_ID_WIDTH) and s_status_error (input, 4): DMA completion status.
REQ-015 SHALL have port m_resp_valid, output, NUM_REQ: one-hot completion strobe routed to the issuing requester.
REQ-016 SHALL have port m_resp_id, output, CMD_ID_WIDTH: completed command ID.
REQ-017 SHALL have port m_resp_error, output, 4: completed command error code.
REQ-018 SHALL have port outstanding, output, $clog2(MAX_OUTSTANDING)+1: number of commands in flight.
REQ-019 SHALL have port spurious_status, output, 1: sticky flag, status received with nothing in flight.

Function
REQ-020 SHALL use a two-state output FSM: EMPTY (m_cmd_valid=0) and HOLD (m_cmd_valid=1, registered command held stable).
REQ-021 SHALL grant in EMPTY, or in HOLD in the same cycle as m_cmd_ready, when any s_cmd_valid is set and the in-flight count plus the held command is less than MAX_OUTSTANDING.
REQ-022 SHALL select the winner round-robin: the lowest-indexed valid requester strictly after the last granted index, wrapping at NUM_REQ-1 to 0; the last granted index resets to NUM_REQ-1.
REQ-023 SHALL assert s_cmd_ready only for the winner, only in the grant cycle; the command is registered and m_cmd_valid asserts the next cycle (latency 1).
REQ-024 SHALL push the winner index into an in-order tracking FIFO of depth MAX_OUTSTANDING on each m_cmd_valid&m_cmd_ready handshake, and increment outstanding.
REQ-025 SHALL handle s_status_valid with outstanding>0 as follows: pop the FIFO; one cycle later, pulse m_resp_valid[popped index] with m_resp_id=s_status_tag and m_resp_error=s_status_error registered; decrement outstanding.
REQ-026 SHALL leave outstanding unchanged and push and pop correctly when an issue and a status occur in the same cycle.
REQ-027 SHALL ignore s_status_valid with outstanding=0 (no response pulse, no underflow) and set spurious_status until reset.
REQ-028 SHALL block grants while outstanding=MAX_OUTSTANDING, and SHALL grant again in the cycle after the first status.
REQ-029 SHALL never drop or reorder m_cmd_* while m_cmd_valid=1 and m_cmd_ready=0.

Reset
REQ-030 SHALL, on rst asserted (asynchronously), drive m_cmd_valid=0, s_cmd_ready=0, m_resp_valid=0, m_resp_id=0, m_resp_error=0, outstanding=0 and spurious_status=0, empty the FIFO, and return the FSM to EMPTY.
REQ-031 SHALL discard commands in flight at reset; their later status is treated per REQ-027.

Configuration
REQ-032 SHALL, with macro PSPIN_EGRESS_ARB_STATS_EN defined, add output stat_issued (NUM_REQ*32): per-requester wrapping count of issued commands, reset 0, incremented on the m_cmd handshake.
REQ-033 SHALL, without PSPIN_EGRESS_ARB_STATS_EN, have no stat_issued port and no counter logic; all other behaviour is identical.

Verification
REQ-034 SHALL verify: both requesters valid continuously, m_cmd_ready=1 -> grants alternate 0,1,0,1; first grant is requester 0.
REQ-035 SHALL verify: 5 commands from requester 1, no status, MAX_OUTSTANDING=4 -> exactly 4 issued; outstanding=4; 5th issued the cycle after one status.
REQ-036 SHALL verify: issue A (req0) then B (req1); status tag=A error=0, then tag=B error=3 -> m_resp_valid=01 then 10, m_resp_error=0 then 3.
REQ-037 SHALL verify: m_cmd_ready held 0 for 10 cycles -> m_cmd_* stable, s_cmd_ready=0 for both requesters.
REQ-038 SHALL verify: status with outstanding=0 -> no m_resp_valid, spurious_status=1, outstanding stays 0.
REQ-039 SHALL verify: rst pulsed with 3 commands in flight -> all outputs 0 immediately; the next command is issued normally.
